// File: rtl/des_msg_loader.sv
`default_nettype none
// ============================================================================
// Module   : des_msg_loader
// Purpose  : Packs a byte stream into 64-bit blocks and offers each block to
//            the DES core as two 32-bit halves; collection is double-buffered.
//            Optional LOADER_FLUSH_EN: flush submits a zero-padded partial block.
// Revision : 1.0 - initial release
// ============================================================================
module des_msg_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:1]  byte_in,
    input  logic        byte_valid,
    input  logic        flush,
    input  logic        read_part1,
    input  logic        done,
    output logic [32:1] msg,
    output logic        ready_part1,
    output logic        ready_part2,
    output logic        byte_ready,
    output logic        overflow
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_OFFER1 = 2'd2,
        ST_OFFER2 = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [64:1] r_coll_buf;
    logic [64:1] w_coll_buf_next;
    logic [2:0]  r_byte_cnt;
    logic        r_coll_full;
    logic        r_overflow;
    logic [32:1] r_xfer_lo;
    logic [32:1] r_msg;
    logic [32:1] w_msg_next;
    logic        w_accept;
    logic        w_load;
    logic        w_flush;

    assign w_accept = byte_valid && !r_coll_full;

`ifdef LOADER_FLUSH_EN
    assign w_flush = flush && !r_coll_full && (r_byte_cnt != 3'd0);
`else
    logic w_unused_flush;
    assign w_unused_flush = flush;
    assign w_flush        = 1'b0;
`endif

    // Byte 0 clears the rest of the buffer, so a flushed block is already zero-padded.
    always_comb begin
        w_coll_buf_next = r_coll_buf;
        if (w_accept) begin
            if (r_byte_cnt == 3'd0) begin
                w_coll_buf_next = {byte_in, 56'd0};
            end else begin
                for (int k = 1; k < 8; k++) begin
                    if (r_byte_cnt == 3'(k)) begin
                        w_coll_buf_next[64-8*k -: 8] = byte_in;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_coll_buf  <= '0;
            r_byte_cnt  <= 3'd0;
            r_coll_full <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_coll_buf <= w_coll_buf_next;
            if (byte_valid && r_coll_full) begin
                r_overflow <= 1'b1;
            end
            if (w_flush) begin
                r_byte_cnt <= 3'd0;
            end else if (w_accept) begin
                r_byte_cnt <= r_byte_cnt + 3'd1;
            end
            if (w_load) begin
                r_coll_full <= 1'b0;
            end else if ((w_accept && (r_byte_cnt == 3'd7)) || w_flush) begin
                r_coll_full <= 1'b1;
            end
        end
    end

    // The upper half goes straight to msg at the copy, so SETUP already drives it.
    always_comb begin
        w_state_next = r_state;
        w_msg_next   = r_msg;
        w_load       = 1'b0;
        ready_part1  = 1'b0;
        ready_part2  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_coll_full) begin
                    w_load       = 1'b1;
                    w_msg_next   = r_coll_buf[64:33];
                    w_state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_state_next = ST_OFFER1;
            end
            ST_OFFER1: begin
                ready_part1 = 1'b1;
                if (read_part1) begin
                    w_msg_next   = r_xfer_lo;
                    w_state_next = ST_OFFER2;
                end
            end
            ST_OFFER2: begin
                ready_part2 = 1'b1;
                if (done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_msg     <= '0;
            r_xfer_lo <= '0;
        end else begin
            r_state <= w_state_next;
            r_msg   <= w_msg_next;
            if (w_load) begin
                r_xfer_lo <= r_coll_buf[32:1];
            end
        end
    end

    assign msg        = r_msg;
    assign byte_ready = !r_coll_full;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_des_msg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_msg_loader
// Purpose  : Directed bench for des_msg_loader with a DES-core responder and a
//            scoreboard of expected half-blocks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_des_msg_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:1]  byte_in;
    logic        byte_valid;
    logic        flush;
    logic        read_part1 = 1'b0;
    logic        done       = 1'b0;
    logic [32:1] msg;
    logic        ready_part1;
    logic        ready_part2;
    logic        byte_ready;
    logic        overflow;

    des_msg_loader dut (
        .clk         (clk),
        .rst         (rst),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .flush       (flush),
        .read_part1  (read_part1),
        .done        (done),
        .msg         (msg),
        .ready_part1 (ready_part1),
        .ready_part2 (ready_part2),
        .byte_ready  (byte_ready),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [32:1] exp_q[$];
    logic [64:1] asm_blk;
    int          asm_cnt;

    int core_st     = 0;
    int core_cnt    = 0;
    int blocks_done = 0;
    int rp1_delay;
    int done_delay;
    bit done_hold;
    bit done_stuck;
    int b2b_blk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_byte(input logic [8:1] b);
        asm_blk[64-8*asm_cnt -: 8] = b;
        asm_cnt++;
        if (asm_cnt == 8) begin
            exp_q.push_back(asm_blk[64:33]);
            exp_q.push_back(asm_blk[32:1]);
            asm_blk = '0;
            asm_cnt = 0;
        end
    endtask

    task automatic model_flush();
        if (asm_cnt > 0) begin
            exp_q.push_back(asm_blk[64:33]);
            exp_q.push_back(asm_blk[32:1]);
            asm_blk = '0;
            asm_cnt = 0;
        end
    endtask

    // Waits for byte_ready with byte_valid low, then presents one byte for one edge.
    task automatic send_byte(input logic [8:1] b);
        int n = 0;
        byte_valid = 1'b0;
        while (!byte_ready && n < 200) begin
            tick();
            n++;
        end
        if (!byte_ready) check("send_wait", byte_ready, 1'b1);
        byte_valid = 1'b1;
        byte_in    = b;
        model_byte(b);
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic wait_blocks(input int target, input int budget);
        int n = 0;
        while (blocks_done < target && n < budget) begin
            tick();
            n++;
        end
        check("block_count", blocks_done, target);
    endtask

    // Core responder: pops/compares each half as it is offered.
    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            core_st    = 0;
            read_part1 = 1'b0;
            done       = 1'b0;
        end else begin
            case (core_st)
                0: begin
                    read_part1 = 1'b0;
                    done       = done_stuck;
                    if (ready_part1) begin
                        if (exp_q.size() == 0) begin
                            check("spurious_offer", ready_part1, 1'b0);
                        end else begin
                            check("part1_msg", msg, exp_q.pop_front());
                            core_cnt = rp1_delay;
                            core_st  = 1;
                        end
                    end
                end
                1: begin
                    check("rp1_hold", ready_part1, 1'b1);
                    check("rp2_low_in_offer1", ready_part2, 1'b0);
                    core_cnt--;
                    if (core_cnt <= 0) begin
                        read_part1 = 1'b1;
                        core_st    = 2;
                    end
                end
                2: begin
                    read_part1 = 1'b0;
                    check("rp2_rise", ready_part2, 1'b1);
                    check("rp1_fall", ready_part1, 1'b0);
                    if (exp_q.size() > 0) check("part2_msg", msg, exp_q.pop_front());
                    else check("part2_missing", ready_part2, 1'b0);
                    core_cnt = done_delay;
                    core_st  = done_stuck ? 3 : 5;
                end
                5: begin
                    if (!done_hold) begin
                        if (core_cnt > 0) begin
                            core_cnt--;
                        end else begin
                            done    = 1'b1;
                            core_st = 3;
                        end
                    end
                end
                3: begin
                    check("rp2_drop", ready_part2, 1'b0);
                    done = done_stuck;
                    blocks_done++;
                    core_st = (blocks_done == b2b_blk) ? 4 : 0;
                end
                4: begin
                    check("b2b_byte_ready", byte_ready, 1'b1);
                    check("b2b_setup_rp1", ready_part1, 1'b0);
                    if (exp_q.size() > 0) check("b2b_setup_msg", msg, exp_q[0]);
                    core_st = 0;
                end
                default: core_st = 0;
            endcase
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_in    = '0;
        flush      = 1'b0;
        rp1_delay  = 3;
        done_delay = 2;
        done_hold  = 1'b0;
        done_stuck = 1'b0;
        b2b_blk    = -1;
        asm_blk    = '0;
        asm_cnt    = 0;
        tick();
        tick();
        check("rst_msg", msg, 32'h0);
        check("rst_rp1", ready_part1, 1'b0);
        check("rst_rp2", ready_part2, 1'b0);
        check("rst_byte_ready", byte_ready, 1'b1);
        check("rst_overflow", overflow, 1'b0);
        rst = 1'b0;
        tick();

        // Byte packing and handoff latency
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        check("pk_full", byte_ready, 1'b0);
        tick();
        check("pk_setup_byte_ready", byte_ready, 1'b1);
        check("pk_setup_msg", msg, 32'h01020304);
        check("pk_setup_rp1", ready_part1, 1'b0);
        tick();
        check("pk_offer_rp1", ready_part1, 1'b1);
        wait_blocks(1, 100);

        // Double buffering: second block collected while the first awaits done
        done_delay = 10;
        base       = blocks_done;
        b2b_blk    = base + 1;
        for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i));
        check("db_full", byte_ready, 1'b0);
        repeat (3) tick();
        check("db_hold", byte_ready, 1'b0);
        wait_blocks(base + 2, 200);

        // Overflow with done withheld
        done_delay = 2;
        done_hold  = 1'b1;
        base       = blocks_done;
        for (int i = 0; i < 16; i++) send_byte(8'hA0 + 8'(i));
        check("ov_pre", overflow, 1'b0);
        check("ov_full", byte_ready, 1'b0);
        byte_valid = 1'b1;
        byte_in    = 8'hEE;
        tick();
        byte_valid = 1'b0;
        check("ov_set", overflow, 1'b1);
        repeat (4) tick();
        check("ov_sticky", overflow, 1'b1);
        done_hold = 1'b0;
        wait_blocks(base + 2, 200);
        check("ov_sticky_after", overflow, 1'b1);

        // Asynchronous reset in OFFER2 with a partial block collected
        done_hold = 1'b1;
        for (int i = 0; i < 8; i++) send_byte(8'h31 + 8'(i));
        for (int i = 0; i < 3; i++) send_byte(8'h41 + 8'(i));
        n = 0;
        while (core_st != 5 && n < 100) begin
            tick();
            n++;
        end
        if (core_st != 5) check("rst_reach_offer2", ready_part2, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_msg", msg, 32'h0);
        check("arst_rp1", ready_part1, 1'b0);
        check("arst_rp2", ready_part2, 1'b0);
        check("arst_byte_ready", byte_ready, 1'b1);
        check("arst_overflow", overflow, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        exp_q.delete();
        asm_blk   = '0;
        asm_cnt   = 0;
        done_hold = 1'b0;
        tick();
        base = blocks_done;
        for (int i = 0; i < 8; i++) send_byte(8'h51 + 8'(i));
        wait_blocks(base + 1, 100);

        // Stale done held high across a new block
        done_stuck = 1'b1;
        base       = blocks_done;
        for (int i = 0; i < 8; i++) send_byte(8'h61 + 8'(i));
        wait_blocks(base + 1, 100);
        done_stuck = 1'b0;
        repeat (2) tick();

        // Flush of a two-byte partial block
        base = blocks_done;
        send_byte(8'hAA);
        send_byte(8'hBB);
        flush = 1'b1;
        tick();
        flush = 1'b0;
`ifdef LOADER_FLUSH_EN
        model_flush();
        check("fl_full", byte_ready, 1'b0);
        wait_blocks(base + 1, 100);
`else
        repeat (12) tick();
        check("nofl_rp1", ready_part1, 1'b0);
        check("nofl_byte_ready", byte_ready, 1'b1);
        check("nofl_blocks", blocks_done, base);
`endif
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
